// File: rtl/arm_bus_ctrl_if.sv
// ----------------------------------------------------------------------------
// arm_bus_ctrl_if
// Bundles the ARM EIM chip-select-5 pins and the register-file command port
// that arm_bus_ctrl sits between.
//
//   ARM side      : ws_n, rs_n (raw strobes, active low), addr, be_n, din,
//                   dout, dout_oe, dtack_n (active low)
//   Reg-file side : rf_addr, rf_wdata, rf_be, rf_we, rf_re, rf_rdata
//
// Modports
//   slave  : the controller (samples ARM pins, drives rf_* and read return)
//   master : the surroundings (ARM pads plus register file)
// ----------------------------------------------------------------------------
interface arm_bus_ctrl_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic              ws_n;
    logic              rs_n;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be_n;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_oe;
    logic              dtack_n;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [BE_W-1:0]   rf_be;
    logic              rf_we;
    logic              rf_re;
    logic [DATA_W-1:0] rf_rdata;

    modport slave (
        input  ws_n, rs_n, addr, be_n, din, rf_rdata,
        output dout, dout_oe, dtack_n, rf_addr, rf_wdata, rf_be, rf_we, rf_re
    );

    modport master (
        output ws_n, rs_n, addr, be_n, din, rf_rdata,
        input  dout, dout_oe, dtack_n, rf_addr, rf_wdata, rf_be, rf_we, rf_re
    );
endinterface

// File: rtl/arm_bus_ctrl.sv
// ----------------------------------------------------------------------------
// arm_bus_ctrl
// Sequences ARM EIM chip-select-5 accesses into the FPGA register file.
// The raw read/write strobes are synchronized into clk, their falling edges
// start a transfer: address/byte enables (and write data) are latched, a
// single-cycle rf_we or rf_re is issued, read data is captured after RD_LAT
// cycles, and DTACK is held low until both strobes are seen released.
//
// Ports
//   clk, rst   : fabric clock, asynchronous active-high reset
//   bus        : arm_bus_ctrl_if.slave (ARM pins + register-file port)
//   busy       : state is not IDLE
//   collision  : one-cycle pulse, both strobes fell in the same cycle
//   timeout    : one-cycle pulse, ACK force-released
//
// Build option
//   ARM_BUS_TIMEOUT_EN : when defined, an 8-bit counter force-releases ACK
//                        after TIMEOUT cycles with a strobe still low.
//                        Undefined: ACK waits indefinitely, timeout is 0.
// ----------------------------------------------------------------------------
module arm_bus_ctrl #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int BE_W        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    arm_bus_ctrl_if.slave     bus,
    output logic              busy,
    output logic              collision,
    output logic              timeout
);

    if (SYNC_STAGES < 2 || RD_LAT < 1 || TIMEOUT < 1 || TIMEOUT > 255 ||
        BE_W != DATA_W / 8) begin : g_bad_params
        $error("arm_bus_ctrl: illegal parameter combination");
    end

    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_ACK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
    logic [SYNC_STAGES-1:0] rs_sync_q, rs_sync_d;
    logic [SYNC_STAGES-1:0] init_q, init_d;
    logic                   ws_prev_q, ws_prev_d;
    logic                   rs_prev_q, rs_prev_d;
    logic                   armed_q, armed_d;
    logic [LAT_W-1:0]       rd_cnt_q, rd_cnt_d;

    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   dout_oe_q, dout_oe_d;
    logic                   dtack_n_q, dtack_n_d;
    logic [ADDR_W-1:0]      rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]      rf_wdata_q, rf_wdata_d;
    logic [BE_W-1:0]        rf_be_q, rf_be_d;
    logic                   rf_we_q, rf_we_d;
    logic                   rf_re_q, rf_re_d;
    logic                   busy_q, busy_d;
    logic                   collision_q, collision_d;
    logic                   timeout_q, timeout_d;

`ifdef ARM_BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]             to_cnt_q, to_cnt_d;
`endif

    logic ws_s, rs_s, ws_fall, rs_fall, released, sync_ok;

    assign ws_s     = ws_sync_q[SYNC_STAGES-1];
    assign rs_s     = rs_sync_q[SYNC_STAGES-1];
    assign ws_fall  = ws_prev_q & ~ws_s;
    assign rs_fall  = rs_prev_q & ~rs_s;
    assign released = ws_s & rs_s;
    // init_q tracks when the synchronizer outputs reflect the pins rather than
    // their reset value; until then a "high" strobe cannot arm the controller.
    assign sync_ok  = init_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        ws_sync_d   = {ws_sync_q[SYNC_STAGES-2:0], bus.ws_n};
        rs_sync_d   = {rs_sync_q[SYNC_STAGES-2:0], bus.rs_n};
        init_d      = {init_q[SYNC_STAGES-2:0], 1'b1};
        ws_prev_d   = ws_s;
        rs_prev_d   = rs_s;
        armed_d     = armed_q | (sync_ok & released);
        rd_cnt_d    = rd_cnt_q;
        dout_d      = dout_q;
        dout_oe_d   = dout_oe_q;
        dtack_n_d   = dtack_n_q;
        rf_addr_d   = rf_addr_q;
        rf_wdata_d  = rf_wdata_q;
        rf_be_d     = rf_be_q;
        rf_we_d     = 1'b0;
        rf_re_d     = 1'b0;
        collision_d = 1'b0;
        timeout_d   = 1'b0;
`ifdef ARM_BUS_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // A strobe must have been seen high since reset or a forced
                // release, otherwise a held-low strobe would look like an edge.
                if (armed_q && (ws_fall || rs_fall)) begin
                    rf_addr_d = bus.addr;
                    rf_be_d   = ~bus.be_n;
                    rd_cnt_d  = '0;
                    if (ws_fall) begin
                        rf_wdata_d  = bus.din;
                        rf_we_d     = |(~bus.be_n);
                        collision_d = rs_fall;
                        state_d     = S_WRITE;
                    end else begin
                        rf_re_d = 1'b1;
                        state_d = S_READ;
                    end
                end
            end

            S_WRITE: begin
                dtack_n_d = 1'b0;
                state_d   = S_ACK;
`ifdef ARM_BUS_TIMEOUT_EN
                to_cnt_d  = '0;
`endif
            end

            S_READ: begin
                if (rd_cnt_q == LAT_W'(RD_LAT)) begin
                    dout_d    = bus.rf_rdata;
                    dout_oe_d = 1'b1;
                    dtack_n_d = 1'b0;
                    state_d   = S_ACK;
`ifdef ARM_BUS_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end

            S_ACK: begin
                if (released) begin
                    dtack_n_d = 1'b1;
                    dout_oe_d = 1'b0;
                    state_d   = S_IDLE;
                end
`ifdef ARM_BUS_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    dtack_n_d = 1'b1;
                    dout_oe_d = 1'b0;
                    timeout_d = 1'b1;
                    armed_d   = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
`endif
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ws_sync_q   <= '1;
            rs_sync_q   <= '1;
            init_q      <= '0;
            ws_prev_q   <= 1'b1;
            rs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            rd_cnt_q    <= '0;
            dout_q      <= '0;
            dout_oe_q   <= 1'b0;
            dtack_n_q   <= 1'b1;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            rf_be_q     <= '0;
            rf_we_q     <= 1'b0;
            rf_re_q     <= 1'b0;
            busy_q      <= 1'b0;
            collision_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef ARM_BUS_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ws_sync_q   <= ws_sync_d;
            rs_sync_q   <= rs_sync_d;
            init_q      <= init_d;
            ws_prev_q   <= ws_prev_d;
            rs_prev_q   <= rs_prev_d;
            armed_q     <= armed_d;
            rd_cnt_q    <= rd_cnt_d;
            dout_q      <= dout_d;
            dout_oe_q   <= dout_oe_d;
            dtack_n_q   <= dtack_n_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_be_q     <= rf_be_d;
            rf_we_q     <= rf_we_d;
            rf_re_q     <= rf_re_d;
            busy_q      <= busy_d;
            collision_q <= collision_d;
            timeout_q   <= timeout_d;
`ifdef ARM_BUS_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_oe  = dout_oe_q;
    assign bus.dtack_n  = dtack_n_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.rf_be    = rf_be_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_re    = rf_re_q;
    assign busy         = busy_q;
    assign collision    = collision_q;
    assign timeout      = timeout_q;

endmodule

// File: doc/arm_bus_ctrl.md
Name: arm_bus_ctrl

Overview:
- Sequences ARM EIM chip-select-5 accesses (CPLD_RS5_B / CPLD_WS5_B strobes) into the FPGA register file.
- Synchronizes the asynchronous strobes into the fabric clock and latches address, byte enables and write data.
- Issues single-cycle register-file read/write commands and drives the read data bus and DTACK back to the ARM.
- Sits between the top-level ARM pins and reg_file and replaces the tied-off DTACK.

Parameters:
ADDR_W, 24, register-file address width
DATA_W, 32, data bus width
BE_W, 4, byte-enable width (DATA_W/8)
SYNC_STAGES, 2, flops in each strobe synchronizer (min 2)
RD_LAT, 1, register-file read latency in clk cycles (min 1)
TIMEOUT, 255, max ACK-state cycles before forced release (8-bit counter)

Ports:
clk  in  1  fabric clock
rst  in  1  asynchronous, active-high reset
ws_n  in  1  raw write strobe, active low
rs_n  in  1  raw read strobe, active low
addr  in  ADDR_W  ARM address, stable while strobe is low
be_n  in  BE_W  ARM byte enables, active low
din  in  DATA_W  ARM write data
dout  out  DATA_W  read data to ARM pads
dout_oe  out  1  pad output enable for dout
dtack_n  out  1  transfer acknowledge to ARM, active low
rf_addr  out  ADDR_W  register-file address
rf_wdata  out  DATA_W  register-file write data
rf_be  out  BE_W  register-file byte enables, active high
rf_we  out  1  one-cycle write command
rf_re  out  1  one-cycle read command
rf_rdata  in  DATA_W  register-file read data
busy  out  1  high when state is not IDLE
collision  out  1  one-cycle pulse: ws and rs fell in the same cycle
timeout  out  1  one-cycle pulse: ACK force-released

Behaviour:
- Reset (async, any time, including mid-transfer) sets:
  - synchronizer flops to 1
  - dtack_n=1, dout_oe=0, dout=0, rf_we=0, rf_re=0, busy=0, collision=0, timeout=0
  - rf_addr=0, rf_wdata=0, rf_be=0
  - state=IDLE
- Strobes pass through SYNC_STAGES flops, then an edge register. Falling edge = synced value 0 and previous value 1.
- Edge-detect cycle E: in IDLE, latch addr to rf_addr and ~be_n to rf_be. On a write, also latch din to rf_wdata.
- State IDLE:
  - ws fall -> WRITE.
  - rs fall -> READ.
  - Both fall in the same cycle -> WRITE; collision=1 at E+1.
  - Edges seen outside IDLE are ignored.
- State WRITE:
  - Cycle E+1: rf_we=1 if rf_be!=0; no write if all byte enables are inactive.
  - Next state ACK.
- State READ:
  - Cycle E+1: rf_re=1.
  - Wait RD_LAT cycles, then capture rf_rdata into dout at E+1+RD_LAT.
  - Next state ACK.
- State ACK:
  - dtack_n=0 (write: from E+2; read: from E+2+RD_LAT).
  - For a read, dout_oe=1 in the same cycle as dtack_n=0.
  - Stays until both synced strobes are 1, then -> IDLE.
- On entering IDLE: dtack_n=1 and dout_oe=0 in the same cycle. dout holds its last value.
- Back-to-back: a new falling edge is accepted on the first IDLE cycle. Earliest restart is one cycle after the release is seen.
- rf_we and rf_re are never high together and never high for more than one cycle.

Optional Feature:
ARM_BUS_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on ACK entry and increments each ACK cycle.
  - When the count reaches TIMEOUT with a strobe still low: -> IDLE, dtack_n=1, dout_oe=0, timeout pulses one cycle.
  - Before re-arming, the strobe must be seen high at least once; a held-low strobe is not a new edge.
- Undefined: no counter; ACK waits indefinitely; timeout tied 0.

Test Plan:
- Write: addr=0x000010, be_n=4'b0000, din=0xDEADBEEF, ws_n low for 10 cycles -> rf_we pulse at E+1 with rf_addr=0x10, rf_wdata=0xDEADBEEF, rf_be=4'hF. dtack_n low from E+2 until ws_n release is synced.
- Read, RD_LAT=1: rs_n low, addr=0x000010, rf_rdata=0xDEADBEEF -> rf_re at E+1; dout=0xDEADBEEF with dout_oe=1 and dtack_n=0 at E+3. Both drop the cycle the release is seen.
- Byte-lane write be_n=4'b1110 -> rf_be=4'b0001. Write with be_n=4'b1111 -> no rf_we, but dtack_n still asserts.
- ws_n and rs_n fall in the same cycle -> WRITE path only, collision pulse at E+1, no rf_re.
- rst asserted during ACK of a read -> dtack_n=1 and dout_oe=0 immediately (asynchronously). After rst is released with rs_n still low, no transfer starts until rs_n goes high then low again.
- With ARM_BUS_TIMEOUT_EN and TIMEOUT=8: rs_n held low 20 cycles -> timeout pulse, dtack_n high after 8 ACK cycles, no second rf_re.
